// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/register stage wrapped around an external ALU.
// Owns PC, A, D, IR and the memory-read latch; talks to ROM/RAM with valid handshakes.
module hack_cpu_ctrl #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic [15:0]       rom_data,
  input  logic              rom_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    MREAD  = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       a_q;
  logic [15:0]       d_q;
  logic [15:0]       ir_q;
  logic [15:0]       m_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              take;

  // Jump condition from the ALU flags of the current computation
  assign take   = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc_q  <= ADDR_W'(RESET_PC);
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
      m_q   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (rom_valid) begin
            ir_q  <= rom_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!ir_q[15]) begin
            a_q   <= ir_q;
            pc_q  <= pc_inc;
            state <= FETCH;
          end else if (ir_q[12]) begin
            state <= MREAD;
          end else begin
            state <= EXEC;
          end
        end
        MREAD: begin
          if (mem_rvalid) begin
            m_q   <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Non-blocking updates: jump target and write address see the old A
          if (ir_q[5]) a_q <= alu_out;
          if (ir_q[4]) d_q <= alu_out;
          pc_q  <= take ? a_q[ADDR_W-1:0] : pc_inc;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are plain state decodes, gated so reset silences them immediately
  assign rom_req   = (state == FETCH) & ~reset;
  assign mem_rd    = (state == MREAD) & ~reset;
  assign mem_wr    = (state == EXEC) & ir_q[3] & ~reset;

  assign rom_addr  = pc_q;
  assign mem_addr  = a_q[ADDR_W-1:0];
  assign mem_wdata = alu_out;
  assign alu_x     = d_q;
  assign alu_y     = ir_q[12] ? m_q : a_q;
  assign alu_ctrl  = ir_q[11:6];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: instruction-level Hack model feeds a scoreboard of
// expected fetches, reads, writes and per-instruction cycle counts.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] rom_addr;
  logic        rom_req;
  logic [15:0] rom_data = '0;
  logic        rom_valid = 1'b0;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctrl;
  logic        alu_zr, alu_ng;

  hack_cpu_ctrl #(.ADDR_W(15), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data), .rom_valid(rom_valid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    o = c[1] ? 16'(a + b) : (a & b);
    if (c[0]) o = ~o;
    return o;
  endfunction

  // External ALU
  assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  typedef struct { logic [14:0] addr; int cyc; } fetch_t;
  typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;

  fetch_t      fetch_q[$];
  wr_t         wr_q[$];
  logic [14:0] rd_q[$];

  logic [15:0] rom  [0:32767];
  logic [15:0] ram  [0:32767];
  logic [15:0] mram [0:32767];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  int checks = 0;
  int errors = 0;
  int n_issued = 0;
  int next_mwait = 0;
  int rom_maxw = 0;
  int mem_lo = 3;
  bit hold = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected (t=%0t)", nm, $time);
  endtask

  // One instruction of the architectural model; pushes everything the DUT must show for it
  task automatic model_step(input logic [15:0] ir, input int rw);
    fetch_t      f;
    wr_t         w;
    logic [15:0] y, out;
    logic [14:0] nxt;
    int          mw;
    bit          take;
    nxt = 15'(m_pc + 15'd1);
    if (!ir[15]) begin
      m_a   = ir;
      f.cyc = rw + 2;
    end else begin
      mw = 0;
      if (ir[12]) begin
        mw = $urandom_range(3, mem_lo);
        next_mwait = mw;
        rd_q.push_back(m_a[14:0]);
        y = mram[m_a[14:0]];
      end else begin
        y = m_a;
      end
      out  = hack_alu(m_d, y, ir[11:6]);
      take = (ir[2] && $signed(out) < 0) || (ir[1] && out == 0) || (ir[0] && $signed(out) > 0);
      if (ir[3]) begin
        w.addr = m_a[14:0];
        w.data = out;
        wr_q.push_back(w);
        mram[m_a[14:0]] = out;
      end
      if (take) nxt = m_a[14:0];
      if (ir[5]) m_a = out;
      if (ir[4]) m_d = out;
      f.cyc = ir[12] ? rw + mw + 4 : rw + 3;
    end
    m_pc   = nxt;
    f.addr = m_pc;
    fetch_q.push_back(f);
  endtask

  // ROM responder with random wait states and stray valids outside fetch
  initial begin : rom_drv
    bit pend;
    int w, wt;
    pend = 0; w = 0; wt = 0;
    forever begin
      @(negedge clk);
      rom_valid = 1'b0;
      rom_data  = 16'h0000;
      if (reset) begin
        pend = 0;
      end else if (rom_req) begin
        if (!pend) begin
          pend = 1;
          w    = $urandom_range(rom_maxw, 0);
          wt   = w;
        end
        if (!hold) begin
          if (w == 0) begin
            rom_valid = 1'b1;
            rom_data  = rom[rom_addr];
            model_step(rom[m_pc], wt);
            n_issued++;
            pend = 0;
          end else begin
            w--;
          end
        end
      end else begin
        pend = 0;
        if ($urandom_range(3, 0) == 0) begin
          rom_valid = 1'b1;
          rom_data  = 16'($urandom);
        end
      end
    end
  end

  // RAM responder: commits writes, answers reads after the wait chosen by the model
  initial begin : mem_drv
    bit pend;
    int w;
    pend = 0; w = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      if (reset) begin
        pend = 0;
      end else begin
        if (mem_wr) ram[mem_addr] = mem_wdata;
        if (mem_rd) begin
          if (!pend) begin
            pend = 1;
            w    = next_mwait;
          end
          if (w == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ram[mem_addr];
            pend = 0;
          end else begin
            w--;
          end
        end else begin
          pend = 0;
          if ($urandom_range(3, 0) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch, read or write
  initial begin : monitor
    bit     pr, pm;
    int     cyc;
    fetch_t f;
    wr_t    wv;
    pr = 0; pm = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pr = 0; pm = 0; cyc = 0;
      end else begin
        cyc++;
        if (rom_req && !pr) begin
          if (fetch_q.size() == 0) fail("fetch_unexpected");
          else begin
            f = fetch_q.pop_front();
            check("fetch_addr", 32'(rom_addr), 32'(f.addr));
            if (f.cyc != 0) check("instr_cycles", 32'(cyc), 32'(f.cyc));
          end
          cyc = 0;
        end
        pr = rom_req;
        if (mem_rd && !pm) begin
          if (rd_q.size() == 0) fail("read_unexpected");
          else check("read_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
        end
        pm = mem_rd;
        if (mem_wr) begin
          if (wr_q.size() == 0) fail("write_unexpected");
          else begin
            wv = wr_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(wv.addr));
            check("write_data", 32'(mem_wdata), 32'(wv.data));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    hold  = 1'b0;
    fetch_q.delete();
    wr_q.delete();
    rd_q.delete();
    m_a = '0;
    m_d = '0;
    m_pc = 15'd0;
    n_issued = 0;
    for (int i = 0; i < 32768; i++) mram[i] = ram[i];
    fetch_q.push_back('{addr: 15'd0, cyc: 0});
    repeat (2) begin
      @(negedge clk);
      check("strobes_in_reset", {29'd0, rom_req, mem_rd, mem_wr}, 32'd0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("first_fetch_req_addr", {16'd0, rom_req, rom_addr}, {16'd0, 1'b1, 15'd0});
  endtask

  task automatic wait_issued(input int n);
    for (int i = 0; i < 20000 && n_issued < n; i++) @(negedge clk);
    if (n_issued < n) check("issue_timeout", 32'(n_issued), 32'(n));
  endtask

  task automatic drain();
    hold = 1'b1;
    repeat (12) @(negedge clk);
    check("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : control
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'($urandom);
    end
    ram[7] = 16'd9;
    // Directed program: plan items 1-6
    rom[0]  = 16'h0005; rom[1]  = 16'hFC10; rom[2]  = 16'h0005; rom[3]  = 16'hEC10;
    rom[4]  = 16'h0064; rom[5]  = 16'hE7C8; rom[6]  = 16'hEE90; rom[7]  = 16'h0028;
    rom[8]  = 16'hE304;
    rom[40] = 16'hEFD0; rom[41] = 16'h0028; rom[42] = 16'hE304; rom[43] = 16'hEA90;
    rom[44] = 16'h0032; rom[45] = 16'hE302;
    rom[50] = 16'h0007; rom[51] = 16'hFC10; rom[52] = 16'hFDE8; rom[53] = 16'h7FFF;
    rom[54] = 16'hEA87;
    rom[32767] = 16'h0000;
    rom_maxw = 0;
    mem_lo   = 3;
    do_reset();
    begin : wait_mread
      int i;
      for (i = 0; i < 50 && !mem_rd; i++) begin
        @(posedge clk);
        #2;
      end
      check("reach_mread", 32'(mem_rd), 32'd1);
    end
    do_reset();
    wait_issued(21);
    drain();

    // Random programs with wait states, including a mid-run reset
    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(9, 0) < 4)
        rom[i] = ($urandom_range(1, 0) == 0) ? 16'($urandom_range(15, 0)) : {1'b0, 15'($urandom)};
      else
        rom[i] = 16'h8000 | 16'($urandom);
    end
    rom_maxw = 2;
    mem_lo   = 0;
    do_reset();
    wait_issued(200);
    repeat ($urandom_range(4, 0)) @(negedge clk);
    do_reset();
    wait_issued(200);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
